// File: rtl/ram_pdp_sync_fifo.sv
// Single-clock FIFO on an inferred pseudo-dual-port RAM, with occupancy count and full/empty/almost flags.
// Latency: a popped word appears on rd_data with rd_valid one cycle after rd_en is accepted.
// Backpressure: writes while full and reads while empty are dropped. Define RAM_PDP_FIFO_ERR_FLAGS_EN for sticky ovf_err/unf_err.
module ram_pdp_sync_fifo #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 9,
    parameter int AFULL_TH  = 480,
    parameter int AEMPTY_TH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              almost_full,
`ifdef RAM_PDP_FIFO_ERR_FLAGS_EN
    output logic              ovf_err,
    output logic              unf_err,
`endif
    output logic              almost_empty
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   AF_C    = (ADDR_W+1)'(AFULL_TH);
    localparam logic [ADDR_W:0]   AE_C    = (ADDR_W+1)'(AEMPTY_TH);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    if (AFULL_TH > DEPTH) begin : g_chk_afull
        $error("AFULL_TH must not exceed DEPTH");
    end
    if (AEMPTY_TH >= DEPTH) begin : g_chk_aempty
        $error("AEMPTY_TH must be below DEPTH");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wr_acc;
    logic              rd_acc;
    logic [ADDR_W:0]   next_count;

    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    always_comb begin
        next_count = count + {{ADDR_W{1'b0}}, wr_acc} - {{ADDR_W{1'b0}}, rd_acc};
    end

    // Storage is kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr  <= rd_ptr + PTR_ONE;
                rd_data <= mem[rd_ptr];
            end
            rd_valid     <= rd_acc;
            count        <= next_count;
            full         <= (next_count == DEPTH_C);
            empty        <= (next_count == '0);
            almost_full  <= (next_count >= AF_C);
            almost_empty <= (next_count <= AE_C);
        end
    end

`ifdef RAM_PDP_FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            ovf_err <= ovf_err | (wr_en & full);
            unf_err <= unf_err | (rd_en & empty);
        end
    end
`endif

endmodule

// File: tb/tb_ram_pdp_sync_fifo.sv
// Directed bench for ram_pdp_sync_fifo at its default 512x8 geometry, with a queue scoreboard.
module tb_ram_pdp_sync_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_en = 1'b0;
    logic       full, empty, rd_valid, almost_full, almost_empty;
    logic [7:0] rd_data;
    logic [9:0] count;
`ifdef RAM_PDP_FIFO_ERR_FLAGS_EN
    logic       ovf_err, unf_err;
    logic       m_ovf = 1'b0, m_unf = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] q[$];
    logic [7:0] m_rdata = 8'h00;
    logic       m_valid = 1'b0;

    ram_pdp_sync_fifo dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .empty        (empty),
        .count        (count),
        .almost_full  (almost_full),
`ifdef RAM_PDP_FIFO_ERR_FLAGS_EN
        .ovf_err      (ovf_err),
        .unf_err      (unf_err),
`endif
        .almost_empty (almost_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        int sz;
        sz = q.size();
        chk("count", 32'(count), 32'(sz));
        chk("full", 32'(full), 32'(sz == 512));
        chk("empty", 32'(empty), 32'(sz == 0));
        chk("almost_full", 32'(almost_full), 32'(sz >= 480));
        chk("almost_empty", 32'(almost_empty), 32'(sz <= 32));
        chk("rd_valid", 32'(rd_valid), 32'(m_valid));
        chk("rd_data", 32'(rd_data), 32'(m_rdata));
`ifdef RAM_PDP_FIFO_ERR_FLAGS_EN
        chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
        chk("unf_err", 32'(unf_err), 32'(m_unf));
`endif
    endtask

    // Drive one cycle of requests, advance the scoreboard, then compare.
    task automatic cycle(input logic we, input logic [7:0] wd, input logic re);
        logic wacc, racc;
        wr_en = we; wr_data = wd; rd_en = re;
        wacc = we && (q.size() < 512);
        racc = re && (q.size() > 0);
`ifdef RAM_PDP_FIFO_ERR_FLAGS_EN
        if (we && q.size() == 512) m_ovf = 1'b1;
        if (re && q.size() == 0) m_unf = 1'b1;
`endif
        @(posedge clk);
        #1;
        m_valid = racc;
        if (racc) m_rdata = q.pop_front();
        if (wacc) q.push_back(wd);
        wr_en = 1'b0; rd_en = 1'b0;
        check_state();
    endtask

    task automatic do_reset(input logic hold_req);
        rst_n = 1'b0; wr_en = hold_req; rd_en = hold_req; wr_data = 8'hCC;
        @(posedge clk);
        #1;
        rst_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        q.delete();
        m_rdata = 8'h00;
        m_valid = 1'b0;
`ifdef RAM_PDP_FIFO_ERR_FLAGS_EN
        m_ovf = 1'b0; m_unf = 1'b0;
`endif
        check_state();
    endtask

    initial begin
        logic [7:0] v;
        #1;
        do_reset(1'b0);
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_count", 32'(count), 32'd0);

        // Three writes, three reads with one-cycle latency
        cycle(1'b1, 8'h11, 1'b0);
        cycle(1'b1, 8'h22, 1'b0);
        cycle(1'b1, 8'h33, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        chk("t1_d0", 32'(rd_data), 32'h11);
        cycle(1'b0, 8'h00, 1'b1);
        chk("t1_d1", 32'(rd_data), 32'h22);
        cycle(1'b0, 8'h00, 1'b1);
        chk("t1_d2", 32'(rd_data), 32'h33);
        chk("t1_valid", 32'(rd_valid), 32'd1);
        chk("t1_empty", 32'(empty), 32'd1);
        cycle(1'b0, 8'h00, 1'b1);
        chk("t1_rdv_off", 32'(rd_valid), 32'd0);
        chk("t1_held", 32'(rd_data), 32'h33);

        // Fill to full across the pointer wrap, drop an extra write, drain
        for (int i = 0; i < 512; i++) begin
            v = i[7:0];
            cycle(1'b1, v, 1'b0);
            if (i == 478) chk("t2_af_479", 32'(almost_full), 32'd0);
            if (i == 479) chk("t2_af_480", 32'(almost_full), 32'd1);
        end
        chk("t2_full", 32'(full), 32'd1);
        chk("t2_count", 32'(count), 32'd512);
        cycle(1'b1, 8'hEE, 1'b0);
        chk("t2_drop_count", 32'(count), 32'd512);
        for (int i = 0; i < 512; i++) begin
            v = i[7:0];
            cycle(1'b0, 8'h00, 1'b1);
            chk("t2_rd", 32'(rd_data), 32'(v));
        end
        chk("t2_empty", 32'(empty), 32'd1);

        // Simultaneous read/write while full
        for (int i = 0; i < 512; i++) begin
            v = i[7:0];
            cycle(1'b1, v, 1'b0);
        end
        cycle(1'b1, 8'hEE, 1'b1);
        chk("t3_count", 32'(count), 32'd511);
        chk("t3_full", 32'(full), 32'd0);
        chk("t3_data", 32'(rd_data), 32'h00);
        for (int i = 0; i < 511; i++) cycle(1'b0, 8'h00, 1'b1);
        chk("t3_last", 32'(rd_data), 32'hFF);
        chk("t3_empty", 32'(empty), 32'd1);

        // Simultaneous read/write while empty
        cycle(1'b1, 8'hA5, 1'b1);
        chk("t4_rdv", 32'(rd_valid), 32'd0);
        chk("t4_count", 32'(count), 32'd1);
        cycle(1'b0, 8'h00, 1'b1);
        chk("t4_data", 32'(rd_data), 32'hA5);

        // Steady-state streaming at occupancy 100, then reset mid-stream
        for (int i = 0; i < 100; i++) begin
            v = i[7:0];
            cycle(1'b1, v, 1'b0);
        end
        for (int i = 0; i < 1000; i++) begin
            v = 8'(i * 7 + 3);
            cycle(1'b1, v, 1'b1);
        end
        chk("t5_count", 32'(count), 32'd100);
        do_reset(1'b1);
        chk("t5_rst_count", 32'(count), 32'd0);
        chk("t5_rst_empty", 32'(empty), 32'd1);
        chk("t5_rst_rdv", 32'(rd_valid), 32'd0);
        chk("t5_rst_wptr", 32'(dut.wr_ptr), 32'd0);
        cycle(1'b1, 8'h5A, 1'b0);
        chk("t5_wptr", 32'(dut.wr_ptr), 32'd1);
        cycle(1'b0, 8'h00, 1'b1);
        chk("t5_data", 32'(rd_data), 32'h5A);

`ifdef RAM_PDP_FIFO_ERR_FLAGS_EN
        // Sticky error flags
        cycle(1'b0, 8'h00, 1'b1);
        chk("t6_unf", 32'(unf_err), 32'd1);
        for (int i = 0; i < 512; i++) begin
            v = i[7:0];
            cycle(1'b1, v, 1'b0);
        end
        chk("t6_unf_sticky", 32'(unf_err), 32'd1);
        chk("t6_ovf_pre", 32'(ovf_err), 32'd0);
        cycle(1'b1, 8'h77, 1'b0);
        chk("t6_ovf", 32'(ovf_err), 32'd1);
        cycle(1'b0, 8'h00, 1'b1);
        chk("t6_ovf_sticky", 32'(ovf_err), 32'd1);
        do_reset(1'b0);
        chk("t6_ovf_clr", 32'(ovf_err), 32'd0);
        chk("t6_unf_clr", 32'(unf_err), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
